// File: rtl/pll_lock_seq.sv
// PLL lock supervisor and core reset sequencer, clocked by the PLL reference clock.
// Holds the PLL in reset, waits for a qualified lock, then releases the core reset.
module pll_lock_seq #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W               = 20
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       lock_lost,
   output logic [3:0] retry_count
);
   // state      | meaning
   // RESET_PLL  | pll_rst and sys_reset high, counting the PLL reset hold time
   // WAIT_LOCK  | pll_rst low, waiting for locked_s with a timeout
   // STABLE     | locked_s seen, counting consecutive locked cycles
   // RUN        | core released, watching for lock loss
   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Timers are down-counters loaded with N-1 on state entry; terminal count is zero.
   localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       sync_q;
   logic             locked_s;
   logic             cnt_tc;

   assign locked_s = sync_q[1];
   assign cnt_tc   = (cnt == '0);

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state       <= RESET_PLL;
         cnt         <= RST_LOAD;
         sync_q      <= 2'b00;
         pll_rst     <= 1'b1;
         sys_reset   <= 1'b1;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         sync_q    <= {sync_q[0], locked};
         lock_lost <= 1'b0;
         if (soft_reset_req) begin
            state     <= RESET_PLL;
            cnt       <= RST_LOAD;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            if (state == RUN && !locked_s)
               lock_lost <= 1'b1;
         end else begin
            case (state)
               RESET_PLL: begin
                  pll_rst   <= 1'b1;
                  sys_reset <= 1'b1;
                  if (cnt_tc) begin
                     state   <= WAIT_LOCK;
                     cnt     <= TIMEOUT_LOAD;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               WAIT_LOCK: begin
                  if (locked_s) begin
                     state <= STABLE;
                     cnt   <= STABLE_LOAD;
                  end else if (cnt_tc) begin
                     state   <= RESET_PLL;
                     cnt     <= RST_LOAD;
                     pll_rst <= 1'b1;
                     if (retry_count != 4'd15)
                        retry_count <= retry_count + 4'd1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               STABLE: begin
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= TIMEOUT_LOAD;
                  end else if (cnt_tc) begin
                     state     <= RUN;
                     sys_reset <= 1'b0;
                     ready     <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               RUN: begin
                  if (!locked_s) begin
                     state     <= RESET_PLL;
                     cnt       <= RST_LOAD;
                     pll_rst   <= 1'b1;
                     sys_reset <= 1'b1;
                     ready     <= 1'b0;
                     lock_lost <= 1'b1;
                  end
               end
               default: begin
                  state     <= RESET_PLL;
                  cnt       <= RST_LOAD;
                  pll_rst   <= 1'b1;
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

PLL lock supervisor and reset sequencer. Runs on the PLL's reference clock, which stays valid while the PLL output does not. It drives the PLL's active-high `rst` input and consumes the PLL's asynchronous `locked` output. It releases the core reset only after the lock has been stable for a programmed time. On lock timeout or lock loss it re-resets the PLL, and it reports retry and lock-loss status.

## Interface
- `PLL_RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per PLL reset pulse.
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles synchronized lock must hold before the core is released.
- `LOCK_TIMEOUT_CYCLES`, 1000000: maximum cycles to wait for first lock assertion before retrying.
- `CNT_W`, 20: cycle counter width. All three cycle parameters must be ≥1 and ≤ 2^CNT_W.

Ports:
- `refclk`  in  1  block clock (50 MHz reference).
- `rst_n`  in  1  synchronous, active-low reset.
- `locked`  in  1  PLL lock, asynchronous to refclk.
- `soft_reset_req`  in  1  single-cycle request to re-sequence the PLL.
- `pll_rst`  out  1  to PLL `rst`, active-high.
- `sys_reset`  out  1  core reset, active-high.
- `ready`  out  1  high only in RUN.
- `lock_lost`  out  1  one-cycle pulse on lock loss while in RUN.
- `retry_count`  out  4  count of lock timeouts, saturating at 15.

## Operation
- `locked` passes through a 2-FF synchronizer to give `locked_s`. The FSM uses only `locked_s`.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN. All outputs are registered and update on the same edge as the state.
- Reset (`rst_n`=0 at an edge):
  - state = RESET_PLL, cnt = 0, synchronizer = 0.
  - `pll_rst`=1, `sys_reset`=1, `ready`=0, `lock_lost`=0, `retry_count`=0.
- RESET_PLL:
  - `pll_rst`=1 and `sys_reset`=1.
  - When cnt == PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0, `pll_rst`=0. Otherwise cnt++.
- WAIT_LOCK:
  - If `locked_s`=1: go to STABLE, cnt=0.
  - Else if cnt == LOCK_TIMEOUT_CYCLES-1: go to RESET_PLL, cnt=0, `pll_rst`=1, `retry_count`++ (saturating at 15).
  - Otherwise cnt++.
- STABLE:
  - If `locked_s`=0: go to WAIT_LOCK, cnt=0. No retry increment; the timeout window restarts.
  - Else if cnt == LOCK_STABLE_CYCLES-1: go to RUN, `sys_reset`=0, `ready`=1.
  - Otherwise cnt++.
- RUN:
  - Hold while `locked_s`=1.
  - If `locked_s`=0: go to RESET_PLL, cnt=0, `pll_rst`=1, `sys_reset`=1, `ready`=0, `lock_lost`=1 for exactly one cycle.
- `soft_reset_req`=1 in any state:
  - Go to RESET_PLL with cnt=0, `pll_rst`=1, `sys_reset`=1, `ready`=0.
  - In RESET_PLL it restarts the hold count.
  - `retry_count` is unchanged.
  - `lock_lost` does not pulse unless a RUN lock loss happens on the same edge; in that case `lock_lost` pulses.
- Priority per edge: `rst_n` > `soft_reset_req` > state rules.
- `retry_count` is cleared only by `rst_n`.

## Timing
- `locked` to FSM latency: 2 edges. A `locked` fall in RUN asserts `pll_rst`/`sys_reset` and pulses `lock_lost` at the 3rd rising edge after the fall.
- Edges are counted from the first edge with `rst_n`=1. With `locked` already high and the synchronizer primed:
  - `pll_rst` falls at edge PLL_RST_CYCLES.
  - STABLE is entered one edge later.
  - `ready` rises at edge PLL_RST_CYCLES + 1 + LOCK_STABLE_CYCLES.
- Timeout retry: `pll_rst` re-asserts LOCK_TIMEOUT_CYCLES edges after WAIT_LOCK entry.
- Glitch handling: a `locked` pulse shorter than one refclk period is either missed or seen for at least one cycle. A single-cycle `locked_s` drop in STABLE restarts the stability count.
- `sys_reset` never deasserts while `pll_rst`=1. `ready` == !`sys_reset` at all times.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
1. Nominal lock: hold `locked`=1 through reset, then release `rst_n` -> `pll_rst` falls at edge 4, `ready`=1 and `sys_reset`=0 at edge 13, `retry_count`=0.
2. Timeout and saturation: `locked`=0 forever -> `pll_rst` rises at edge 36 with `retry_count`=1, falls at edge 40, and re-asserts every 36 cycles; `retry_count` stops at 15 after the 15th timeout.
3. Unstable lock: assert `locked`, then drop it 3 cycles into STABLE -> FSM returns to WAIT_LOCK with no retry increment; `ready` rises 8 cycles after `locked_s` is stable again.
4. Lock loss in RUN: drop `locked` -> at the 3rd edge `lock_lost` is 1 for one cycle, `pll_rst`=1, `sys_reset`=1, `ready`=0; with `locked` restored, `ready` returns after 4+1+8 cycles.
5. Soft reset: pulse `soft_reset_req` in RUN -> `pll_rst` is high for 4 cycles, `lock_lost` stays 0, `retry_count` is unchanged. Pulse it again mid-RESET_PLL -> the hold count restarts.
6. Mid-operation reset: drive `rst_n` low during WAIT_LOCK with `retry_count`=3 -> at the next edge all outputs return to reset values and `retry_count`=0.
